// File: rtl/fp_align_stage_vec.sv
// Multi-lane FP-add alignment stage: picks the result exponent, arithmetically right-shifts
// significand2 with a sticky bit, and buffers beats in a 2-entry skid buffer with flush.
module fp_align_stage_vec #(
    parameter int EXPONENT_WIDTH    = 8,
    parameter int SIGNIFICAND_WIDTH = 23,
    parameter int NUM_LANES         = 16,
    parameter int SHIFT_WIDTH       = 6,
    localparam int SW               = SIGNIFICAND_WIDTH + 3
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                flush_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [5:0]                          operation_i,
    input  logic [NUM_LANES*SHIFT_WIDTH-1:0]    align_shift_i,
    input  logic [NUM_LANES-1:0]                exponent2_larger_i,
    input  logic [NUM_LANES*EXPONENT_WIDTH-1:0] exponent1_i,
    input  logic [NUM_LANES*EXPONENT_WIDTH-1:0] exponent2_i,
    input  logic [NUM_LANES*SW-1:0]             significand1_i,
    input  logic [NUM_LANES*SW-1:0]             significand2_i,
    input  logic [NUM_LANES-1:0]                result_is_inf_i,
    input  logic [NUM_LANES-1:0]                result_is_nan_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [5:0]                          operation_o,
    output logic [NUM_LANES*EXPONENT_WIDTH-1:0] exponent_o,
    output logic [NUM_LANES*SW-1:0]             significand1_o,
    output logic [NUM_LANES*SW-1:0]             significand2_o,
    output logic [NUM_LANES-1:0]                sticky_o,
    output logic [NUM_LANES-1:0]                result_is_inf_o,
    output logic [NUM_LANES-1:0]                result_is_nan_o
);

    typedef struct packed {
        logic [5:0]                          operation;
        logic [NUM_LANES*EXPONENT_WIDTH-1:0] exponent;
        logic [NUM_LANES*SW-1:0]             significand1;
        logic [NUM_LANES*SW-1:0]             significand2;
        logic [NUM_LANES-1:0]                sticky;
        logic [NUM_LANES-1:0]                result_is_inf;
        logic [NUM_LANES-1:0]                result_is_nan;
    } beat_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    beat_t  in_beat, out_q, skid_q;
    logic   take_in, take_out;

    always_comb begin
        logic [SHIFT_WIDTH-1:0] sh;
        logic [SW-1:0]          s2;
        logic [SW-1:0]          mask;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_beat               = '0;
        in_beat.operation     = operation_i;
        in_beat.significand1  = significand1_i;
        in_beat.result_is_inf = result_is_inf_i;
        in_beat.result_is_nan = result_is_nan_i;
        sh                    = '0;
        s2                    = '0;
        mask                  = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            sh   = align_shift_i[l*SHIFT_WIDTH +: SHIFT_WIDTH];
            s2   = significand2_i[l*SW +: SW];
            // Shifting ones left by >= SW leaves nothing, so the mask covers every bit then.
            mask = ~({SW{1'b1}} << sh);
            in_beat.significand2[l*SW +: SW] = $signed(s2) >>> sh;
            in_beat.sticky[l] = |(s2 & mask);
            in_beat.exponent[l*EXPONENT_WIDTH +: EXPONENT_WIDTH] = exponent2_larger_i[l]
                ? exponent2_i[l*EXPONENT_WIDTH +: EXPONENT_WIDTH]
                : exponent1_i[l*EXPONENT_WIDTH +: EXPONENT_WIDTH];
        end
    end

    assign valid_o  = (state != EMPTY);
    assign ready_o  = (state != TWO);
    assign take_in  = valid_i && ready_o;
    assign take_out = valid_o && ready_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            // NOTE: both data registers are reset so the outputs read all-zero out of reset.
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: if (take_in) begin
                    out_q <= in_beat;
                    state <= ONE;
                end
                ONE: begin
                    if (take_in && take_out) begin
                        out_q <= in_beat;
                    end else if (take_in) begin
                        skid_q <= in_beat;
                        state  <= TWO;
                    end else if (take_out) begin
                        state <= EMPTY;
                    end
                end
                TWO: if (take_out) begin
                    out_q <= skid_q;
                    state <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign operation_o     = out_q.operation;
    assign exponent_o      = out_q.exponent;
    assign significand1_o  = out_q.significand1;
    assign significand2_o  = out_q.significand2;
    assign sticky_o        = out_q.sticky;
    assign result_is_inf_o = out_q.result_is_inf;
    assign result_is_nan_o = out_q.result_is_nan;

endmodule

// File: tb/tb_fp_align_stage_vec.sv
// Directed bench for fp_align_stage_vec: hand-computed lane 0 vectors, random other lanes
// checked against a bit-serial shift model, plus backpressure, flush and mid-stream reset.
module tb_fp_align_stage_vec;

    localparam int EW = 8;
    localparam int SGW = 23;
    localparam int SW = SGW + 3;
    localparam int NL = 16;
    localparam int SH = 6;

    typedef struct packed {
        logic [5:0]       op;
        logic [NL*EW-1:0] exp;
        logic [NL*SW-1:0] s1;
        logic [NL*SW-1:0] s2;
        logic [NL-1:0]    st;
        logic [NL-1:0]    inf;
        logic [NL-1:0]    nan;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [5:0]       operation_i;
    logic [NL*SH-1:0] align_shift_i;
    logic [NL-1:0]    exponent2_larger_i;
    logic [NL*EW-1:0] exponent1_i, exponent2_i;
    logic [NL*SW-1:0] significand1_i, significand2_i;
    logic [NL-1:0]    result_is_inf_i, result_is_nan_i;
    logic             valid_o;
    logic             ready_i;
    logic [5:0]       operation_o;
    logic [NL*EW-1:0] exponent_o;
    logic [NL*SW-1:0] significand1_o, significand2_o;
    logic [NL-1:0]    sticky_o, result_is_inf_o, result_is_nan_o;

    int n_checks = 0;
    int n_fail = 0;

    fp_align_stage_vec #(
        .EXPONENT_WIDTH(EW), .SIGNIFICAND_WIDTH(SGW), .NUM_LANES(NL), .SHIFT_WIDTH(SH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .operation_i(operation_i), .align_shift_i(align_shift_i),
        .exponent2_larger_i(exponent2_larger_i), .exponent1_i(exponent1_i),
        .exponent2_i(exponent2_i), .significand1_i(significand1_i),
        .significand2_i(significand2_i), .result_is_inf_i(result_is_inf_i),
        .result_is_nan_i(result_is_nan_i), .valid_o(valid_o), .ready_i(ready_i),
        .operation_o(operation_o), .exponent_o(exponent_o), .significand1_o(significand1_o),
        .significand2_o(significand2_o), .sticky_o(sticky_o),
        .result_is_inf_o(result_is_inf_o), .result_is_nan_o(result_is_nan_o)
    );

    always #5 clk = ~clk;

    // Lane 0 directed vectors with hand-computed results.
    logic [SW-1:0] t_s2  [6] = '{26'h0800000, 26'h0800001, 26'h3800000, 26'h0000005, 26'h3FFFFFF, 26'h1234567};
    logic [SH-1:0] t_sh  [6] = '{6'd4, 6'd1, 6'd4, 6'd40, 6'd40, 6'd0};
    logic [EW-1:0] t_e1  [6] = '{8'h80, 8'h10, 8'h01, 8'h7F, 8'hFE, 8'h33};
    logic [EW-1:0] t_e2  [6] = '{8'h84, 8'h20, 8'h02, 8'h7E, 8'h01, 8'h44};
    logic          t_l   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [SW-1:0] t_res [6] = '{26'h0080000, 26'h0400000, 26'h3F80000, 26'h0000000, 26'h3FFFFFF, 26'h1234567};
    logic          t_st  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [EW-1:0] t_eo  [6] = '{8'h84, 8'h10, 8'h02, 8'h7F, 8'h01, 8'h44};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: one arithmetic step per shift position, collecting lost bits.
    function automatic void model_lane(input logic [SW-1:0] s, input logic [SH-1:0] sh,
                                       output logic [SW-1:0] r, output logic st);
        r  = s;
        st = 1'b0;
        for (int i = 0; i < int'(sh); i++) begin
            st = st | r[0];
            r  = {r[SW-1], r[SW-1:1]};
        end
    endfunction

    task automatic drive(input logic [SW-1:0] s2_0, input logic [SH-1:0] sh_0,
                         input logic [EW-1:0] e1_0, input logic [EW-1:0] e2_0,
                         input logic l_0, output beat_t e);
        logic [31:0]   r;
        logic [SW-1:0] s1, s2, res;
        logic [SH-1:0] sh;
        logic [EW-1:0] e1, e2;
        logic          lg, st;
        r           = $urandom;
        operation_i = r[5:0];
        e.op        = r[5:0];
        for (int l = 0; l < NL; l++) begin
            r  = $urandom; s2 = r[SW-1:0];
            r  = $urandom; s1 = r[SW-1:0];
            r  = $urandom;
            sh = r[SH-1:0]; e1 = r[15:8]; e2 = r[23:16]; lg = r[24];
            if (l == 0) begin
                s2 = s2_0; sh = sh_0; e1 = e1_0; e2 = e2_0; lg = l_0;
            end
            model_lane(s2, sh, res, st);
            align_shift_i[l*SH +: SH]   = sh;
            exponent1_i[l*EW +: EW]     = e1;
            exponent2_i[l*EW +: EW]     = e2;
            exponent2_larger_i[l]       = lg;
            significand1_i[l*SW +: SW]  = s1;
            significand2_i[l*SW +: SW]  = s2;
            result_is_inf_i[l]          = r[25];
            result_is_nan_i[l]          = r[26];
            e.exp[l*EW +: EW]           = lg ? e2 : e1;
            e.s1[l*SW +: SW]            = s1;
            e.s2[l*SW +: SW]            = res;
            e.st[l]                     = st;
            e.inf[l]                    = r[25];
            e.nan[l]                    = r[26];
        end
        valid_i = 1'b1;
    endtask

    task automatic check_beat(input string tag, input beat_t e);
        check({tag, "_valid"}, valid_o, 1'b1);
        check({tag, "_op"}, operation_o, e.op);
        for (int l = 0; l < NL; l++) begin
            check($sformatf("%s_exp%0d", tag, l), exponent_o[l*EW +: EW], e.exp[l*EW +: EW]);
            check($sformatf("%s_s1_%0d", tag, l), significand1_o[l*SW +: SW], e.s1[l*SW +: SW]);
            check($sformatf("%s_s2_%0d", tag, l), significand2_o[l*SW +: SW], e.s2[l*SW +: SW]);
            check($sformatf("%s_st%0d", tag, l), sticky_o[l], e.st[l]);
            check($sformatf("%s_inf%0d", tag, l), result_is_inf_o[l], e.inf[l]);
            check($sformatf("%s_nan%0d", tag, l), result_is_nan_o[l], e.nan[l]);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_ready"}, ready_o, 1'b1);
        check({tag, "_op"}, operation_o, 6'd0);
        check({tag, "_exp"}, |exponent_o, 1'b0);
        check({tag, "_s1"}, |significand1_o, 1'b0);
        check({tag, "_s2"}, |significand2_o, 1'b0);
        check({tag, "_st"}, |sticky_o, 1'b0);
        check({tag, "_flags"}, |{result_is_inf_o, result_is_nan_o}, 1'b0);
    endtask

    beat_t ea, eb, ec, ed;

    initial begin
        reset_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        operation_i = '0; align_shift_i = '0; exponent2_larger_i = '0;
        exponent1_i = '0; exponent2_i = '0; significand1_i = '0; significand2_i = '0;
        result_is_inf_i = '0; result_is_nan_i = '0;
        #1 check_zero_outputs("reset");
        @(negedge clk) reset_n = 1'b1;

        // Directed vectors back to back: 1-cycle latency, one beat per cycle.
        for (int v = 0; v < 6; v++) begin
            drive(t_s2[v], t_sh[v], t_e1[v], t_e2[v], t_l[v], ea);
            @(negedge clk);
            check_beat($sformatf("vec%0d", v), ea);
            check($sformatf("vec%0d_l0_s2", v), significand2_o[SW-1:0], t_res[v]);
            check($sformatf("vec%0d_l0_st", v), sticky_o[0], t_st[v]);
            check($sformatf("vec%0d_l0_exp", v), exponent_o[EW-1:0], t_eo[v]);
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("idle_valid", valid_o, 1'b0);
        check("idle_hold_exp", exponent_o[EW-1:0], 8'h44);

        // Backpressure: A held, B to skid, C waits; then A, B, C in order.
        ready_i = 1'b0;
        drive(t_s2[0], t_sh[0], t_e1[0], t_e2[0], t_l[0], ea);
        @(negedge clk);
        check("bp_a_ready", ready_o, 1'b1);
        check_beat("bp_a1", ea);
        drive(t_s2[1], t_sh[1], t_e1[1], t_e2[1], t_l[1], eb);
        @(negedge clk);
        check("bp_two_ready", ready_o, 1'b0);
        check_beat("bp_a2", ea);
        drive(t_s2[2], t_sh[2], t_e1[2], t_e2[2], t_l[2], ec);
        @(negedge clk);
        check("bp_c_wait_ready", ready_o, 1'b0);
        check_beat("bp_a3", ea);
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_b_ready", ready_o, 1'b1);
        check_beat("bp_b", eb);
        @(negedge clk);
        check_beat("bp_c", ec);
        valid_i = 1'b0;
        @(negedge clk);
        check("bp_drained", valid_o, 1'b0);

        // Flush with two buffered beats and a third presented the same cycle.
        ready_i = 1'b0;
        drive(t_s2[3], t_sh[3], t_e1[3], t_e2[3], t_l[3], ed);
        @(negedge clk);
        drive(t_s2[4], t_sh[4], t_e1[4], t_e2[4], t_l[4], ed);
        @(negedge clk);
        check("fl_two_ready", ready_o, 1'b0);
        drive(t_s2[5], t_sh[5], t_e1[5], t_e2[5], t_l[5], ed);
        flush_i = 1'b1;
        @(negedge clk);
        check("fl_valid", valid_o, 1'b0);
        check("fl_ready", ready_o, 1'b1);
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("fl_quiet%0d", i), valid_o, 1'b0);
        end

        // Asynchronous reset while holding two beats.
        ready_i = 1'b0;
        drive(t_s2[0], t_sh[0], t_e1[0], t_e2[0], t_l[0], ed);
        @(negedge clk);
        drive(t_s2[1], t_sh[1], t_e1[1], t_e2[1], t_l[1], ed);
        @(negedge clk);
        check("rs_two_valid", valid_o, 1'b1);
        check("rs_two_ready", ready_o, 1'b0);
        valid_i = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_zero_outputs("rs_async");
        @(negedge clk) reset_n = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rs_quiet%0d", i), valid_o, 1'b0);
        end

        // Recovery after reset.
        drive(t_s2[2], t_sh[2], t_e1[2], t_e2[2], t_l[2], ea);
        @(negedge clk);
        check_beat("post_rs", ea);
        check("post_rs_l0_s2", significand2_o[SW-1:0], t_res[2]);
        valid_i = 1'b0;
        @(negedge clk);
        check("post_rs_idle", valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
